// File: rtl/regfile_dumper.sv
// Walks every register of a regfile read port and streams each one to a UART
// byte transmitter, least-significant byte first, one byte per tx handshake.
module regfile_dumper #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    output logic [4:0]            o_rf_addr,
    input  logic [DATA_WIDTH-1:0] i_rf_data,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_start,
    input  logic                  i_tx_done,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);
    localparam logic [4:0]       LAST_REG  = 5'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT,
        DONE
    } state_t;

    state_t                state;
    logic [4:0]            index;
    logic [CNT_W-1:0]      byte_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            index      <= '0;
            byte_cnt   <= '0;
            shift_reg  <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        index    <= '0;
                        byte_cnt <= '0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    shift_reg <= i_rf_data;
                    byte_cnt  <= '0;
                    state     <= SEND;
                end
                SEND: begin
                    o_tx_start <= 1'b1;
                    o_tx_data  <= shift_reg[7:0];
                    state      <= WAIT;
                end
                WAIT: begin
                    // o_tx_data is left untouched here so the UART sees a stable byte
                    if (i_tx_done) begin
                        if (byte_cnt < LAST_BYTE) begin
                            shift_reg <= shift_reg >> 8;
                            byte_cnt  <= byte_cnt + 1'b1;
                            state     <= SEND;
                        end else if (index < LAST_REG) begin
                            index <= index + 1'b1;
                            state <= LOAD;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Index parks at zero so the read address is 0 whenever idle
                    index <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_rf_addr = index;
    assign o_busy    = (state != IDLE);
    assign o_done    = (state == DONE);

endmodule

// File: tb/tb_regfile_dumper.sv
// Bench for regfile_dumper: a regfile model, a UART model that answers five
// cycles after each tx request, and a byte scoreboard filled from the model.
module tb_regfile_dumper;

    logic        clk;
    logic        i_rst_n;
    logic        i_start;
    logic [4:0]  o_rf_addr;
    logic [31:0] i_rf_data;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        i_tx_done;
    logic        o_busy;
    logic        o_done;

    logic [31:0] rf_mem [32];

    logic [7:0] exp_data [$];
    logic [4:0] exp_addr [$];
    logic [7:0] got_data [$];
    logic [4:0] got_addr [$];
    int         n_done;

    int checks = 0;
    int passes = 0;

    regfile_dumper #(.DATA_WIDTH(32), .NUM_REGS(32)) dut (
        .clk       (clk),
        .i_rst_n   (i_rst_n),
        .i_start   (i_start),
        .o_rf_addr (o_rf_addr),
        .i_rf_data (i_rf_data),
        .o_tx_data (o_tx_data),
        .o_tx_start(o_tx_start),
        .i_tx_done (i_tx_done),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign i_rf_data = rf_mem[o_rf_addr];

    task automatic init_rf();
        for (int r = 0; r < 32; r++) rf_mem[r] = r * 32'h0101_0101;
    endtask

    task automatic fill_expected();
        exp_data.delete();
        exp_addr.delete();
        got_data.delete();
        got_addr.delete();
        n_done = 0;
        for (int r = 0; r < 32; r++) begin
            for (int b = 0; b < 4; b++) begin
                logic [31:0] word;
                word = rf_mem[r] >> (8 * b);
                exp_data.push_back(word[7:0]);
                exp_addr.push_back(5'(r));
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_rst_n   = 1'b0;
        i_start   = 1'b0;
        i_tx_done = 1'b0;
        repeat (2) @(negedge clk);
        i_rst_n = 1'b1;
    endtask

    // Drives the UART side until the dump finishes, abort_at bytes are seen,
    // or the cycle budget runs out (finished stays 0).
    task automatic run_dump(input int abort_at, input bit spurious, output bit finished);
        int uart_cnt;
        bit extra;
        uart_cnt = 0;
        extra    = 1'b0;
        finished = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            i_start   = spurious && o_busy;
            i_tx_done = 1'b0;
            if (extra) begin
                i_tx_done = 1'b1;
                extra     = 1'b0;
            end
            if (o_tx_start) begin
                got_data.push_back(o_tx_data);
                got_addr.push_back(o_rf_addr);
                uart_cnt = 5;
            end else if (uart_cnt > 0) begin
                uart_cnt--;
                if (uart_cnt == 0) begin
                    i_tx_done = 1'b1;
                    extra     = spurious;
                end
            end
            if (o_done) n_done++;
            if (abort_at > 0 && got_data.size() == abort_at) begin
                finished = 1'b1;
                break;
            end
            if (n_done > 0 && !o_busy) begin
                finished = 1'b1;
                break;
            end
        end
        i_start   = 1'b0;
        i_tx_done = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n   = 1'b0;
        i_start   = 1'b1;
        i_tx_done = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if ({o_tx_start, o_busy, o_done} !== 3'b000)
                $display("FAIL reset_ctrl: got start/busy/done=%b want 000", {o_tx_start, o_busy, o_done});
            else passes++;
            checks++;
            if (o_tx_data !== 8'h00 || o_rf_addr !== 5'd0)
                $display("FAIL reset_data: got data=%h addr=%0d want 00/0", o_tx_data, o_rf_addr);
            else passes++;
        end
        i_start = 1'b0;
        i_rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_tx_start !== 1'b0)
            $display("FAIL reset_idle: got busy=%b start=%b want 0/0", o_busy, o_tx_start);
        else passes++;
    endtask

    task automatic test_timing();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        checks++;
        if (o_busy !== 1'b1 || o_tx_start !== 1'b0)
            $display("FAIL timing_e0: got busy=%b start=%b want 1/0", o_busy, o_tx_start);
        else passes++;
        @(negedge clk);
        checks++;
        if (o_tx_start !== 1'b0)
            $display("FAIL timing_e1: got start=%b want 0", o_tx_start);
        else passes++;
        @(negedge clk);
        checks++;
        if (o_tx_start !== 1'b1 || o_tx_data !== 8'h00)
            $display("FAIL timing_e2: got start=%b data=%h want 1/00", o_tx_start, o_tx_data);
        else passes++;
        @(negedge clk);
        checks++;
        if (o_tx_start !== 1'b0 || o_tx_data !== 8'h00)
            $display("FAIL timing_e3: got start=%b data=%h want 0/00", o_tx_start, o_tx_data);
        else passes++;
        do_reset();
    endtask

    task automatic check_dump(input string name, input bit finished);
        checks++;
        if (!finished) $display("FAIL %s_timeout: dump did not finish in budget", name);
        else passes++;
        checks++;
        if (got_data.size() != 128)
            $display("FAIL %s_count: got %0d bytes want 128", name, got_data.size());
        else passes++;
        checks++;
        if (n_done != 1)
            $display("FAIL %s_done: got %0d done pulses want 1", name, n_done);
        else passes++;
        for (int i = 0; i < got_data.size() && exp_data.size() > 0; i++) begin
            logic [7:0] ed;
            logic [4:0] ea;
            ed = exp_data.pop_front();
            ea = exp_addr.pop_front();
            checks++;
            if (got_data[i] !== ed || got_addr[i] !== ea)
                $display("FAIL %s_byte%0d: got %h@%0d want %h@%0d", name, i, got_data[i], got_addr[i], ed, ea);
            else passes++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_tx_start !== 1'b0)
            $display("FAIL %s_idle_after: got busy=%b start=%b want 0/0", name, o_busy, o_tx_start);
        else passes++;
    endtask

    task automatic test_full_dump();
        bit fin;
        init_rf();
        fill_expected();
        @(negedge clk);
        i_start = 1'b1;
        run_dump(0, 1'b0, fin);
        if (got_data.size() == 128) begin
            checks++;
            if ({got_data[4], got_data[5], got_data[6], got_data[7]} !== 32'h01010101)
                $display("FAIL full_reg1: got %h %h %h %h want 01 01 01 01",
                         got_data[4], got_data[5], got_data[6], got_data[7]);
            else passes++;
            checks++;
            if ({got_data[124], got_data[125], got_data[126], got_data[127]} !== 32'h1F1F1F1F)
                $display("FAIL full_reg31: got %h %h %h %h want 1f 1f 1f 1f",
                         got_data[124], got_data[125], got_data[126], got_data[127]);
            else passes++;
        end
        check_dump("full", fin);
    endtask

    task automatic test_byte_order();
        bit fin;
        init_rf();
        rf_mem[5] = 32'hDEAD_BEEF;
        fill_expected();
        @(negedge clk);
        i_start = 1'b1;
        run_dump(0, 1'b0, fin);
        if (got_data.size() == 128) begin
            checks++;
            if ({got_data[20], got_data[21], got_data[22], got_data[23]} !== 32'hEFBEADDE)
                $display("FAIL order_reg5: got %h %h %h %h want ef be ad de",
                         got_data[20], got_data[21], got_data[22], got_data[23]);
            else passes++;
        end
        check_dump("order", fin);
        init_rf();
    endtask

    task automatic test_protocol();
        bit fin;
        init_rf();
        fill_expected();
        @(negedge clk);
        i_start = 1'b1;
        run_dump(0, 1'b1, fin);
        check_dump("protocol", fin);
    endtask

    task automatic test_abort();
        bit fin;
        init_rf();
        fill_expected();
        @(negedge clk);
        i_start = 1'b1;
        run_dump(10, 1'b0, fin);
        checks++;
        if (!fin || got_data.size() != 10)
            $display("FAIL abort_reach: got %0d bytes want 10", got_data.size());
        else passes++;
        i_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        i_rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            checks++;
            if (o_tx_start !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0)
                $display("FAIL abort_quiet%0d: got start/busy/done=%b want 000", c, {o_tx_start, o_busy, o_done});
            else passes++;
            @(negedge clk);
        end
        checks++;
        if (o_rf_addr !== 5'd0)
            $display("FAIL abort_addr: got %0d want 0", o_rf_addr);
        else passes++;
        fill_expected();
        i_start = 1'b1;
        run_dump(0, 1'b0, fin);
        check_dump("restart", fin);
    endtask

    initial begin
        i_rst_n   = 1'b0;
        i_start   = 1'b0;
        i_tx_done = 1'b0;
        init_rf();
        @(negedge clk);
        test_reset();
        test_timing();
        test_full_dump();
        test_byte_order();
        test_protocol();
        test_abort();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/regfile_dumper.md
REGFILE_DUMPER -- requirements
Module: regfile_dumper

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the register width in bits; it must be a multiple of 8.
REQ-002 The block SHALL have parameter NUM_REGS, default 32, giving the number of registers dumped.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port i_rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port i_start, input, 1 bit: request to begin a full register-file dump.
REQ-006 The block SHALL have port o_rf_addr, output, 5 bits: the read address driven to a regfile read port.
REQ-007 The block SHALL have port i_rf_data, input, DATA_WIDTH bits: the combinational read data returned for o_rf_addr.
REQ-008 The block SHALL have port o_tx_data, output, 8 bits: the byte presented to the UART transmitter.
REQ-009 The block SHALL have port o_tx_start, output, 1 bit: a one-cycle request for the UART to send o_tx_data.
REQ-010 The block SHALL have port i_tx_done, input, 1 bit: a one-cycle pulse from the UART when the current byte has completed.
REQ-011 The block SHALL have port o_busy, output, 1 bit: high while a dump is in progress.
REQ-012 The block SHALL have port o_done, output, 1 bit: a one-cycle pulse when a dump completes.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD, SEND, WAIT and DONE, and SHALL keep a register index (5 bits), a byte counter (log2(DATA_WIDTH/8) bits) and a DATA_WIDTH-bit shift register.
REQ-014 In IDLE, when i_start=1 on a clock edge, the block SHALL clear the index and byte counter and go to LOAD; otherwise it SHALL stay in IDLE.
REQ-015 In LOAD, the block SHALL capture i_rf_data for the current o_rf_addr into the shift register, clear the byte counter and go to SEND, taking exactly one cycle.
REQ-016 In SEND, the block SHALL drive o_tx_start=1 for exactly one cycle, with o_tx_data equal to shift register bits [7:0], and then go to WAIT.
REQ-017 In WAIT, the block SHALL hold o_tx_data stable and keep o_tx_start=0 until i_tx_done=1.
REQ-018 On i_tx_done in WAIT with byte counter < DATA_WIDTH/8-1, the block SHALL shift the shift register right by 8, increment the byte counter and go to SEND; bytes are therefore sent LSB first (little-endian).
REQ-019 On i_tx_done in WAIT with the last byte sent and index < NUM_REGS-1, the block SHALL increment the index and go to LOAD.
REQ-020 On i_tx_done in WAIT with the last byte sent and index = NUM_REGS-1, the block SHALL go to DONE; the index SHALL NOT wrap.
REQ-021 In DONE, the block SHALL assert o_done=1 for one cycle and return to IDLE.
REQ-022 o_rf_addr SHALL equal the index at all times, and SHALL be 0 in IDLE.
REQ-023 o_busy SHALL be 1 in the states LOAD, SEND, WAIT and DONE, and 0 in IDLE.
REQ-024 i_start SHALL be ignored in every state other than IDLE, so a dump already in progress is never restarted.
REQ-025 i_tx_done SHALL be ignored in every state other than WAIT.
REQ-026 If i_start=1 during the DONE cycle, it SHALL be ignored; a new dump starts only on an i_start sampled in IDLE.
REQ-027 The block SHALL NOT special-case register 0; it transmits whatever i_rf_data returns for that address.
REQ-028 A complete dump SHALL produce exactly NUM_REGS*DATA_WIDTH/8 o_tx_start pulses, which is 128 with the defaults.
REQ-029 Latency: with i_start sampled at edge n, the first o_tx_start SHALL be high in the cycle after edge n+2.
REQ-030 All outputs SHALL be registered or decoded directly from state; there SHALL be no combinational path from an input to an output.

Reset
REQ-031 When i_rst_n=0 at a rising clk edge, the FSM SHALL go to IDLE and the index, byte counter, shift register, o_tx_data, o_tx_start, o_busy and o_done SHALL all become 0.
REQ-032 Reset SHALL take priority over every other input in the same cycle.
REQ-033 A reset asserted mid-dump SHALL abort the dump with no further o_tx_start and no o_done pulse.

Verification
REQ-034 Reset: hold i_rst_n=0 for 2 cycles with i_start=1 -> all outputs remain 0, and after release the state is IDLE.
REQ-035 Full dump: regfile model returns addr*0x01010101 (reg0=0), and the UART model answers i_tx_done 5 cycles after each o_tx_start -> 128 bytes are sent; reg 1 yields 01,01,01,01; reg 31 yields 1F,1F,1F,1F; o_done pulses once; o_busy then drops.
REQ-036 Byte order: reg 5 = 0xDEADBEEF -> bytes for reg 5 arrive in the order EF, BE, AD, DE.
REQ-037 Protocol: pulse i_start and spurious i_tx_done while in SEND/LOAD during a dump -> no restart and no skipped bytes; the byte count is still 128.
REQ-038 Abort: assert reset after the 10th byte -> no further o_tx_start; o_busy=0; a following i_start begins again at o_rf_addr=0.
REQ-039 Timing: i_start at edge 0 -> o_tx_start=1 only in the cycle after edge 2, and o_tx_data=reg0 byte0=0x00.
